// File: rtl/dmem_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// dmem_port_arbiter_pkg
//   Shared types and constants for the data-memory port arbiter.
//   - WORD_SIZE_P      : address/data width of the memory port
//   - STARVE_MAX_P     : default number of consecutive load grants allowed
//                        while a committed store is waiting
//   - dmem_arb_state_e : arbiter FSM states
//   - mem_req_t        : registered memory request (we/addr/data)
// ----------------------------------------------------------------------------
package dmem_port_arbiter_pkg;

    localparam int WORD_SIZE_P  = 32;
    localparam int STARVE_MAX_P = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } dmem_arb_state_e;

    typedef struct packed {
        logic                   we;
        logic [WORD_SIZE_P-1:0] addr;
        logic [WORD_SIZE_P-1:0] data;
    } mem_req_t;

endpackage

// File: rtl/dmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares the single data-memory port between execute-stage loads and the
//   store-buffer drain of committed stores. One transaction is outstanding
//   at a time; the request is registered toward memory. Loads win by
//   default, but a starvation counter and the store-buffer high-water hint
//   force a store drain so committed stores always make progress.
//
// Ports
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   rob_mispredict_i            flush: blocks new loads, kills in-flight load
//   ld_v_i/ld_addr_i/ld_ready_o load request handshake from execute
//   ld_resp_v_o/ld_resp_data_o  load data back to execute (1-cycle pulse)
//   sb_mem_v_i/sb_mem_addr_i/
//   sb_mem_data_i/sb_mem_ready_o store-buffer head drain handshake
//   sb_high_water_i             store buffer nearly full: store wins
//   mem_req_*                   registered request toward memory
//   mem_resp_v_i/mem_resp_data_i load data returning from memory
// ----------------------------------------------------------------------------
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_P
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   rob_mispredict_i,
    input  logic                   ld_v_i,
    input  logic [WORD_SIZE_P-1:0] ld_addr_i,
    output logic                   ld_ready_o,
    output logic                   ld_resp_v_o,
    output logic [WORD_SIZE_P-1:0] ld_resp_data_o,
    input  logic                   sb_mem_v_i,
    input  logic [WORD_SIZE_P-1:0] sb_mem_addr_i,
    input  logic [WORD_SIZE_P-1:0] sb_mem_data_i,
    output logic                   sb_mem_ready_o,
    input  logic                   sb_high_water_i,
    output logic                   mem_req_v_o,
    output logic                   mem_req_we_o,
    output logic [WORD_SIZE_P-1:0] mem_req_addr_o,
    output logic [WORD_SIZE_P-1:0] mem_req_data_o,
    input  logic                   mem_req_ready_i,
    input  logic                   mem_resp_v_i,
    input  logic [WORD_SIZE_P-1:0] mem_resp_data_i
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    dmem_arb_state_e  r_state;
    mem_req_t         r_req;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_killed;

    logic w_idle;
    logic w_starved;
    logic w_st_grant;
    logic w_ld_grant;
    logic w_resp_fire;

    // Grant decision. Reset is folded into w_idle so the ready outputs are
    // forced low while reset is asserted, not just after the next edge.
    always_comb begin
        w_idle      = reset_n_i && (r_state == IDLE);
        w_starved   = (r_starve_cnt == CNT_W'(STARVE_MAX));
        w_st_grant  = w_idle && sb_mem_v_i &&
                      (!ld_v_i || rob_mispredict_i || sb_high_water_i || w_starved);
        w_ld_grant  = w_idle && !w_st_grant && ld_v_i && !rob_mispredict_i;
        w_resp_fire = (r_state == RESP) && mem_resp_v_i;
    end

    assign ld_ready_o     = w_ld_grant;
    assign sb_mem_ready_o = w_st_grant;

    assign mem_req_v_o    = (r_state == REQ);
    assign mem_req_we_o   = r_req.we;
    assign mem_req_addr_o = r_req.addr;
    assign mem_req_data_o = r_req.data;

    // A mispredict landing in the same cycle as the response also squashes it.
    assign ld_resp_v_o    = w_resp_fire && !r_killed && !rob_mispredict_i;
    assign ld_resp_data_o = ld_resp_v_o ? mem_resp_data_i : '0;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= IDLE;
            r_req        <= '0;
            r_starve_cnt <= '0;
            r_killed     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_st_grant) begin
                        r_req.we     <= 1'b1;
                        r_req.addr   <= sb_mem_addr_i;
                        r_req.data   <= sb_mem_data_i;
                        r_starve_cnt <= '0;
                        r_state      <= REQ;
                    end else if (w_ld_grant) begin
                        r_req.we   <= 1'b0;
                        r_req.addr <= ld_addr_i;
                        r_req.data <= '0;
                        // Only loads that bypass a waiting store count toward starvation.
                        if (sb_mem_v_i && !w_starved) begin
                            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
                        end
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    // The request is never retracted; a flushed load is
                    // marked and its response dropped later.
                    if (!r_req.we && rob_mispredict_i) begin
                        r_killed <= 1'b1;
                    end
                    if (mem_req_ready_i) begin
                        r_state <= r_req.we ? IDLE : RESP;
                    end
                end
                RESP: begin
                    if (mem_resp_v_i) begin
                        r_killed <= 1'b0;
                        r_state  <= IDLE;
                    end else if (rob_mispredict_i) begin
                        r_killed <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Memory only answers loads, and only while we are waiting for one.
    a_resp_only_in_resp: assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        mem_resp_v_i |-> (r_state == RESP)
    );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//   Directed bench for dmem_port_arbiter: reset, lone store, stalled load,
//   starvation pattern, high-water override, mispredict handling and reset
//   in the middle of a request.
// ----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        mis;
    logic        ld_v;
    logic [31:0] ld_addr;
    logic        ld_ready;
    logic        ld_resp_v;
    logic [31:0] ld_resp_data;
    logic        sb_v;
    logic [31:0] sb_addr;
    logic [31:0] sb_data;
    logic        sb_ready;
    logic        hw;
    logic        req_v;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        mem_ready;
    logic        mem_resp_v;
    logic [31:0] mem_resp_data;

    int n_pass;
    int n_total;

    dmem_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .rob_mispredict_i (mis),
        .ld_v_i           (ld_v),
        .ld_addr_i        (ld_addr),
        .ld_ready_o       (ld_ready),
        .ld_resp_v_o      (ld_resp_v),
        .ld_resp_data_o   (ld_resp_data),
        .sb_mem_v_i       (sb_v),
        .sb_mem_addr_i    (sb_addr),
        .sb_mem_data_i    (sb_data),
        .sb_mem_ready_o   (sb_ready),
        .sb_high_water_i  (hw),
        .mem_req_v_o      (req_v),
        .mem_req_we_o     (req_we),
        .mem_req_addr_o   (req_addr),
        .mem_req_data_o   (req_data),
        .mem_req_ready_i  (mem_ready),
        .mem_resp_v_i     (mem_resp_v),
        .mem_resp_data_i  (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Full load from IDLE: grant, accepted request, response.
    task automatic load_txn(input string tag, input logic [31:0] rdata);
        #1;
        chk1({tag, "_ld_ready"}, ld_ready, 1'b1);
        chk1({tag, "_sb_ready"}, sb_ready, 1'b0);
        tick();
        mem_ready = 1'b1;
        #1;
        chk1({tag, "_req_v"}, req_v, 1'b1);
        chk1({tag, "_req_we"}, req_we, 1'b0);
        tick();
        mem_ready     = 1'b0;
        mem_resp_v    = 1'b1;
        mem_resp_data = rdata;
        #1;
        chk1({tag, "_resp_v"}, ld_resp_v, 1'b1);
        chkw({tag, "_resp_data"}, ld_resp_data, rdata);
        tick();
        mem_resp_v = 1'b0;
    endtask

    // Full store from IDLE: grant, accepted request.
    task automatic store_txn(input string tag);
        #1;
        chk1({tag, "_sb_ready"}, sb_ready, 1'b1);
        chk1({tag, "_ld_ready"}, ld_ready, 1'b0);
        tick();
        mem_ready = 1'b1;
        #1;
        chk1({tag, "_req_v"}, req_v, 1'b1);
        chk1({tag, "_req_we"}, req_we, 1'b1);
        tick();
        mem_ready = 1'b0;
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        reset_n       = 1'b0;
        mis           = 1'b0;
        ld_v          = 1'b1;
        ld_addr       = 32'h0;
        sb_v          = 1'b1;
        sb_addr       = 32'h0;
        sb_data       = 32'h0;
        hw            = 1'b0;
        mem_ready     = 1'b0;
        mem_resp_v    = 1'b0;
        mem_resp_data = 32'h0;

        // Reset with requests pending: nothing may be granted.
        #2;
        chk1("rst_ld_ready", ld_ready, 1'b0);
        chk1("rst_sb_ready", sb_ready, 1'b0);
        chk1("rst_req_v", req_v, 1'b0);
        chk1("rst_resp_v", ld_resp_v, 1'b0);
        chkw("rst_req_addr", req_addr, 32'h0);
        tick();
        tick();
        ld_v    = 1'b0;
        sb_v    = 1'b0;
        reset_n = 1'b1;
        tick();

        // Lone store.
        sb_v    = 1'b1;
        sb_addr = 32'h40;
        sb_data = 32'hBEEF;
        #1;
        chk1("st_grant", sb_ready, 1'b1);
        chk1("st_no_ld", ld_ready, 1'b0);
        chk1("st_req_pre", req_v, 1'b0);
        tick();
        sb_v = 1'b0;
        #1;
        chk1("st_req_v", req_v, 1'b1);
        chk1("st_req_we", req_we, 1'b1);
        chkw("st_req_addr", req_addr, 32'h40);
        chkw("st_req_data", req_data, 32'hBEEF);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        #1;
        chk1("st_done", req_v, 1'b0);

        // Load with a two-cycle memory stall.
        ld_v    = 1'b1;
        ld_addr = 32'h80;
        #1;
        chk1("ld_grant", ld_ready, 1'b1);
        tick();
        ld_v = 1'b0;
        #1;
        chk1("ld_req_v0", req_v, 1'b1);
        chk1("ld_req_we", req_we, 1'b0);
        chkw("ld_req_addr0", req_addr, 32'h80);
        tick();
        chk1("ld_req_v1", req_v, 1'b1);
        chkw("ld_req_addr1", req_addr, 32'h80);
        tick();
        chk1("ld_req_v2", req_v, 1'b1);
        chkw("ld_req_addr2", req_addr, 32'h80);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        #1;
        chk1("ld_req_dropped", req_v, 1'b0);
        chk1("ld_resp_wait", ld_resp_v, 1'b0);
        mem_resp_v    = 1'b1;
        mem_resp_data = 32'h1234;
        #1;
        chk1("ld_resp_v", ld_resp_v, 1'b1);
        chkw("ld_resp_data", ld_resp_data, 32'h1234);
        tick();
        mem_resp_v = 1'b0;
        #1;
        chk1("ld_resp_once", ld_resp_v, 1'b0);

        // Starvation: four loads, then a forced store, twice over.
        ld_v    = 1'b1;
        ld_addr = 32'h100;
        sb_v    = 1'b1;
        sb_addr = 32'h200;
        sb_data = 32'h5A5A;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                load_txn("starve_ld", 32'hA000 + 32'(i));
            end
            store_txn("starve_st");
        end

        // High water overrides a partially built-up counter.
        load_txn("hw_ld0", 32'hB000);
        load_txn("hw_ld1", 32'hB001);
        hw = 1'b1;
        store_txn("hw_st");
        hw = 1'b0;
        load_txn("hw_ld_after", 32'hB002);
        ld_v = 1'b0;
        sb_v = 1'b0;

        // Mispredict in IDLE: load refused, store still goes.
        ld_v = 1'b1;
        mis  = 1'b1;
        #1;
        chk1("mis_idle_no_ld", ld_ready, 1'b0);
        sb_v    = 1'b1;
        sb_addr = 32'h300;
        store_txn("mis_idle_st");
        sb_v = 1'b0;
        mis  = 1'b0;

        // Mispredict in RESP, response two cycles later is swallowed.
        ld_addr = 32'h400;
        #1;
        chk1("mis_resp_grant", ld_ready, 1'b1);
        tick();
        ld_v      = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        mis       = 1'b1;
        #1;
        chk1("mis_resp_c0", ld_resp_v, 1'b0);
        tick();
        mis = 1'b0;
        #1;
        chk1("mis_resp_c1", ld_resp_v, 1'b0);
        tick();
        mem_resp_v    = 1'b1;
        mem_resp_data = 32'h5555;
        sb_v          = 1'b1;
        sb_addr       = 32'h44;
        sb_data       = 32'h77;
        #1;
        chk1("mis_resp_killed", ld_resp_v, 1'b0);
        chkw("mis_resp_data", ld_resp_data, 32'h0);
        chk1("mis_resp_no_st", sb_ready, 1'b0);
        tick();
        mem_resp_v = 1'b0;
        #1;
        chk1("mis_then_st", sb_ready, 1'b1);
        tick();
        sb_v      = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk1("mis_st_req_v", req_v, 1'b1);
        chkw("mis_st_req_addr", req_addr, 32'h44);
        tick();
        mem_ready = 1'b0;

        // Killed flag is cleared: next load returns normally.
        ld_v = 1'b1;
        load_txn("post_mis_ld", 32'hC0DE);

        // Mispredict coinciding with the response.
        #1;
        chk1("mis_same_grant", ld_ready, 1'b1);
        tick();
        ld_v      = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready     = 1'b0;
        mem_resp_v    = 1'b1;
        mem_resp_data = 32'h6666;
        mis           = 1'b1;
        #1;
        chk1("mis_same_cycle", ld_resp_v, 1'b0);
        tick();
        mem_resp_v = 1'b0;
        mis        = 1'b0;

        // Reset in the middle of a load request.
        ld_v    = 1'b1;
        ld_addr = 32'h500;
        #1;
        chk1("rst2_grant", ld_ready, 1'b1);
        tick();
        #1;
        chk1("rst2_in_req", req_v, 1'b1);
        reset_n = 1'b0;
        #1;
        chk1("rst2_req_v", req_v, 1'b0);
        chk1("rst2_req_we", req_we, 1'b0);
        chkw("rst2_req_addr", req_addr, 32'h0);
        chk1("rst2_ld_ready", ld_ready, 1'b0);
        chk1("rst2_sb_ready", sb_ready, 1'b0);
        chk1("rst2_resp_v", ld_resp_v, 1'b0);
        ld_v    = 1'b0;
        reset_n = 1'b1;
        tick();
        sb_v    = 1'b1;
        sb_addr = 32'h8;
        #1;
        chk1("rst2_idle_st", sb_ready, 1'b1);
        chk1("rst2_idle_req_v", req_v, 1'b0);
        sb_v = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
